// File: rtl/mux8_pkg.sv
// rtl/mux8_pkg.sv - shared width default and source tag codes for the 3-way mux/demux pair
//
// Purpose: one place for the default channel width and the 2-bit source tags,
//          so the mux tag output and the demux select always agree.
// Contents: W_DEFAULT, SEL_NONE/SEL_Q1/SEL_Q2/SEL_Q3, tag_of() one-hot -> tag.
package mux8_pkg;

  localparam int W_DEFAULT = 8;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_Q1   = 2'b01;
  localparam logic [1:0] SEL_Q2   = 2'b10;
  localparam logic [1:0] SEL_Q3   = 2'b11;

  // Converts a one-hot channel grant into its tag; all-zero maps to SEL_NONE.
  function automatic logic [1:0] tag_of(input logic [2:0] onehot);
    logic [1:0] t;
    t = SEL_NONE;
    if (onehot[0]) t = SEL_Q1;
    if (onehot[1]) t = SEL_Q2;
    if (onehot[2]) t = SEL_Q3;
    return t;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - three-way round-robin grant, purely combinational
//
// Purpose: picks the first valid channel after the last one served.
// Optional feature: MUX8_FORCE_SEL_EN adds fs to pin the grant to one channel.
// Ports:
//   v    [2:0] in  per-channel valid (bit 0 = channel 1)
//   last [1:0] in  tag of the channel served last (00/11 both start at ch1)
//   en         in  grant allowed this cycle
//   fs   [1:0] in  force-select tag, 00 = free round-robin (MUX8_FORCE_SEL_EN only)
//   gnt  [2:0] out one-hot grant, zero when nothing eligible or en low
module rr_arb3
  import mux8_pkg::*;
(
  input  logic [2:0] v,
  input  logic [1:0] last,
  input  logic       en,
`ifdef MUX8_FORCE_SEL_EN
  input  logic [1:0] fs,
`endif
  output logic [2:0] gnt
);

  logic [2:0] elig;
  int         start;
  logic       found;

  always_comb begin
    elig  = v;
`ifdef MUX8_FORCE_SEL_EN
    // Forcing only masks eligibility; the rotation pointer is left alone.
    if (fs != SEL_NONE) elig = v & (3'b001 << (fs - 2'd1));
`endif
    case (last)
      SEL_Q1:  start = 1;
      SEL_Q2:  start = 2;
      default: start = 0;
    endcase
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (en && !found && elig[(start + k) % 3]) begin
        gnt[(start + k) % 3] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_3to1_arb.sv
// rtl/mux8_3to1_arb.sv - round-robin 3-to-1 stream merge with one output register
//
// Purpose: merges three valid/ready sources into one tagged output stream.
// Optional feature: MUX8_FORCE_SEL_EN adds fs to restrict grant to one channel.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i1..i3 [W-1:0]     source data
//   v1..v3 / r1..r3    source valid / ready (r is combinational, data-independent)
//   q [W-1:0], s [1:0] merged data and its source tag (00 = none)
//   qv / qr            output valid / sink ready
//   fs [1:0]           force-select tag (MUX8_FORCE_SEL_EN only)
module mux8_3to1_arb
  import mux8_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef MUX8_FORCE_SEL_EN
  input  logic [1:0]   fs,
`endif
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  input  logic         v1,
  input  logic         v2,
  input  logic         v3,
  output logic         r1,
  output logic         r2,
  output logic         r3,
  output logic [W-1:0] q,
  output logic [1:0]   s,
  output logic         qv,
  input  logic         qr
);

  logic [1:0]   last;
  logic         load;
  logic [2:0]   gnt;
  logic         in_xfer;
  logic [W-1:0] d_sel;

  // The register can take a word when empty or when its word leaves this
  // cycle. rst_n gates the grant so ready drops as soon as reset asserts.
  assign load = !qv || qr;

  rr_arb3 u_arb (
    .v    ({v3, v2, v1}),
    .last (last),
    .en   (load && rst_n),
`ifdef MUX8_FORCE_SEL_EN
    .fs   (fs),
`endif
    .gnt  (gnt)
  );

  assign r1      = gnt[0];
  assign r2      = gnt[1];
  assign r3      = gnt[2];
  assign in_xfer = |gnt;

  always_comb begin
    d_sel = '0;
    if (gnt[0]) d_sel = i1;
    if (gnt[1]) d_sel = i2;
    if (gnt[2]) d_sel = i3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      s    <= SEL_NONE;
      qv   <= 1'b0;
      last <= SEL_Q3;
    end else if (in_xfer) begin
      q    <= d_sel;
      s    <= tag_of(gnt);
      qv   <= 1'b1;
      last <= tag_of(gnt);
    end else if (qv && qr) begin
      // Drain without refill: drop valid and tag, keep the stale data.
      s    <= SEL_NONE;
      qv   <= 1'b0;
    end
  end

endmodule
